// File: rtl/pmp_pkg.sv
// Shared definitions for the PMP pattern-matching target: opcodes, control
// word field positions, engine state encoding and the number of instances.
package pmp_pkg;

    localparam int unsigned NO_MODULES = 4;

    localparam int unsigned OP_HI  = 15;
    localparam int unsigned OP_LO  = 14;
    localparam int unsigned LEN_HI = 13;
    localparam int unsigned LEN_LO = 11;
    localparam int unsigned CNT_HI = 10;
    localparam int unsigned CNT_LO = 8;
    localparam int unsigned RSV_HI = 7;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_SCAN  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SCAN = 2'd2,
        ST_DONE = 2'd3
    } pmp_state_e;

endpackage

// File: rtl/pmp_window_cmp.sv
// Combinational compare of the byte window (index 0 newest) against the
// pattern (index 0 oldest), considering only the first plen_i pattern bytes.
module pmp_window_cmp #(
    parameter int unsigned BYTES = 8
) (
    input  logic [BYTES-1:0][7:0]      window_i,
    input  logic [BYTES-1:0][7:0]      pattern_i,
    input  logic [$clog2(BYTES):0]     plen_i,
    output logic                       match_c_o
);

    localparam int unsigned IDX_W = $clog2(BYTES);
    localparam int unsigned LEN_W = IDX_W + 1;

    // pattern[i] lines up with window[plen-1-i]; bytes past plen are masked
    always_comb begin
        match_c_o = 1'b1;
        for (int i = 0; i < BYTES; i++) begin
            if (LEN_W'(i) < plen_i) begin
                if (pattern_i[i] != window_i[IDX_W'(plen_i - LEN_W'(i) - LEN_W'(1))]) begin
                    match_c_o = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/pmp_match_engine.sv
// Per-module PMP pattern-matching target: four-phase command handshake,
// LOAD/SCAN/CLEAR/NOP execution and a sticky match flag.
// Optional match counter output enabled by `define MATCH_COUNT_EN.
module pmp_match_engine
    import pmp_pkg::*;
#(
    parameter int unsigned BYTES = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [8*BYTES-1:0]   data,
    input  logic [15:0]          control,
    input  logic                 data_ready,
    output logic                 data_accepted,
    output logic                 pattern_accepted,
    output logic                 busy
`ifdef MATCH_COUNT_EN
    ,
    output logic [CNT_W-1:0]     match_count
`endif
);

    localparam int unsigned IDX_W = $clog2(BYTES);
    localparam int unsigned LEN_W = IDX_W + 1;

    pmp_state_e state_q, state_d;

    logic [BYTES-1:0][7:0] data_q, data_d;
    logic [BYTES-1:0][7:0] pat_q, pat_d;
    logic [BYTES-1:0][7:0] hist_q, hist_d;
    logic [IDX_W-1:0]      len_q, len_d;
    logic [IDX_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [LEN_W-1:0]      plen_q, plen_d;
    logic [LEN_W-1:0]      vcnt_q, vcnt_d;
    logic                  pa_q, pa_d;
    logic                  da_q, da_d;
    logic                  busy_q, busy_d;

    logic [1:0]            op_c;
    logic                  take_c;
    logic                  clear_c;
    logic                  scan_hit_c;
    logic                  cmp_hit_c;
    logic                  match_c;
    logic [7:0]            cur_c;
    logic [BYTES-1:0][7:0] window_c;
    logic                  unused_ctrl;

    assign op_c        = control[OP_HI:OP_LO];
    assign unused_ctrl = ^control[RSV_HI:0];
    assign take_c      = (state_q == ST_IDLE) && data_ready && !da_q;
    assign clear_c     = (state_q == ST_LOAD) || (take_c && (op_c == OP_CLEAR));

    assign cur_c    = data_q[idx_q];
    assign window_c = {hist_q[BYTES-2:0], cur_c};

    pmp_window_cmp #(
        .BYTES     (BYTES)
    ) u_cmp (
        .window_i  (window_c),
        .pattern_i (pat_q),
        .plen_i    (plen_q),
        .match_c_o (cmp_hit_c)
    );

    // a match also needs enough valid history to fill the pattern length
    assign match_c    = cmp_hit_c && (LEN_W'(vcnt_q + LEN_W'(1)) >= plen_q);
    assign scan_hit_c = (state_q == ST_SCAN) && match_c;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (take_c) begin
                    case (op_c)
                        OP_LOAD: state_d = ST_LOAD;
                        OP_SCAN: state_d = ST_SCAN;
                        default: state_d = ST_DONE;
                    endcase
                end
            end
            ST_LOAD: state_d = ST_DONE;
            ST_SCAN: if (idx_q == cnt_q) state_d = ST_DONE;
            ST_DONE: if (!data_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        data_d = data_q;
        pat_d  = pat_q;
        hist_d = hist_q;
        len_d  = len_q;
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        plen_d = plen_q;
        vcnt_d = vcnt_q;
        pa_d   = pa_q;

        if (take_c) begin
            data_d = data;
            len_d  = IDX_W'(control[LEN_HI:LEN_LO]);
            cnt_d  = IDX_W'(control[CNT_HI:CNT_LO]);
            idx_d  = '0;
        end
        if (clear_c) begin
            pa_d   = 1'b0;
            vcnt_d = '0;
        end
        if (state_q == ST_LOAD) begin
            pat_d  = data_q;
            plen_d = LEN_W'(len_q) + LEN_W'(1);
        end
        if (state_q == ST_SCAN) begin
            hist_d = window_c;
            idx_d  = idx_q + IDX_W'(1);
            if (vcnt_q != LEN_W'(BYTES)) begin
                vcnt_d = vcnt_q + LEN_W'(1);
            end
        end
        if (scan_hit_c) begin
            pa_d = 1'b1;
        end

        da_d   = (state_d == ST_DONE);
        busy_d = (state_d == ST_LOAD) || (state_d == ST_SCAN);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            data_q <= '0;
            pat_q  <= '0;
            hist_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            plen_q <= LEN_W'(1);
            vcnt_q <= '0;
            pa_q   <= 1'b0;
            da_q   <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            data_q <= data_d;
            pat_q  <= pat_d;
            hist_q <= hist_d;
            len_q  <= len_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            plen_q <= plen_d;
            vcnt_q <= vcnt_d;
            pa_q   <= pa_d;
            da_q   <= da_d;
            busy_q <= busy_d;
        end
    end

    assign data_accepted    = da_q;
    assign pattern_accepted = pa_q;
    assign busy             = busy_q;

`ifdef MATCH_COUNT_EN
    logic [CNT_W-1:0] mcnt_q, mcnt_d;

    // saturating count of matching bytes since the last LOAD/CLEAR
    always_comb begin
        mcnt_d = mcnt_q;
        if (clear_c) begin
            mcnt_d = '0;
        end else if (scan_hit_c && (mcnt_q != '1)) begin
            mcnt_d = mcnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mcnt_q <= '0;
        end else begin
            mcnt_q <= mcnt_d;
        end
    end

    assign match_count = mcnt_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W == 0);
`endif

endmodule
